// File: rtl/brief_pkg.sv
// Shared types, state constants and fixed-point helpers for the steered-BRIEF descriptor engine.
package brief_pkg;

    localparam int Q_FRAC = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

    typedef struct packed {
        logic signed [7:0] x;
        logic signed [7:0] y;
    } point_t;

    // Q1.10 to integer, rounding half-up (floor of v/1024 + 0.5)
    function automatic logic signed [8:0] round_q(input logic signed [20:0] v);
        logic signed [20:0] t_s;
        t_s = v + 21'sd512;
        return 9'(t_s >>> Q_FRAC);
    endfunction

    function automatic int clamp_idx(input logic signed [8:0] v, input int half, input int hi);
        int s;
        s = int'(v) + half;
        if (s < 0) begin
            return 0;
        end else if (s > hi) begin
            return hi;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/brief_stream_desc_if.sv
// Keypoint-in / descriptor-out stream bundle; slave is the engine side, master the producer/consumer side.
interface brief_stream_desc_if #(
    parameter int WIN     = 31,
    parameter int NBITS   = 256,
    parameter int COORD_W = 10,
    parameter int TRIG_W  = 12
);
    logic                              i_valid;
    logic                              o_ready;
    logic [WIN-1:0][WIN-1:0][7:0]      i_window;
    logic [COORD_W-1:0]                i_coor_x;
    logic [COORD_W-1:0]                i_coor_y;
    logic [7:0]                        i_score;
    logic [9:0]                        i_depth;
    logic signed [TRIG_W-1:0]          i_sin;
    logic signed [TRIG_W-1:0]          i_cos;
    logic                              i_unsteered;

    logic                              o_valid;
    logic                              i_ready;
    logic [COORD_W-1:0]                o_coor_x;
    logic [COORD_W-1:0]                o_coor_y;
    logic [7:0]                        o_score;
    logic [9:0]                        o_depth;
    logic [NBITS-1:0]                  o_descriptor;

    modport slave (
        input  i_valid, i_window, i_coor_x, i_coor_y, i_score, i_depth,
               i_sin, i_cos, i_unsteered, i_ready,
        output o_ready, o_valid, o_coor_x, o_coor_y, o_score, o_depth, o_descriptor
    );

    modport master (
        output i_valid, i_window, i_coor_x, i_coor_y, i_score, i_depth,
               i_sin, i_cos, i_unsteered, i_ready,
        input  o_ready, o_valid, o_coor_x, o_coor_y, o_score, o_depth, o_descriptor
    );

endinterface

// File: rtl/brief_pattern_rom.sv
// Fixed test-pair table; returns the PAR point pairs of group g. Entry i is a closed-form
// permutation of the patch so every coordinate stays within +/- WIN/2.
module brief_pattern_rom
    import brief_pkg::*;
#(
    parameter int WIN   = 31,
    parameter int NBITS = 256,
    parameter int PAR   = 16,
    parameter int GW    = 4
) (
    input  logic [GW-1:0] g,
    output point_t        pa [PAR],
    output point_t        pb [PAR]
);

    localparam int HALF = WIN / 2;
    localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;

    point_t tab_a_s [NBITS];
    point_t tab_b_s [NBITS];

    for (genvar i = 0; i < NBITS; i++) begin : g_tab
        assign tab_a_s[i] = {8'(HALF - ((i * 11) % WIN)), 8'(HALF - ((i * 17) % WIN))};
        assign tab_b_s[i] = {8'(((i * 23 + 13) % WIN) - HALF), 8'(((i * 29 + 7) % WIN) - HALF)};
    end

    // select the PAR consecutive entries of the requested group
    always_comb begin
        for (int k = 0; k < PAR; k++) begin
            pa[k] = tab_a_s[IW'(int'(g) * PAR + k)];
            pb[k] = tab_b_s[IW'(int'(g) * PAR + k)];
        end
    end

endmodule

// File: rtl/brief_stream_desc.sv
// Time-multiplexed steered-BRIEF engine: PAR rotated pair tests per cycle through a
// 3-stage product/rotate/compare pipeline, one NBITS descriptor per keypoint.
module brief_stream_desc
    import brief_pkg::*;
#(
    parameter int WIN     = 31,
    parameter int NBITS   = 256,
    parameter int PAR     = 16,
    parameter int COORD_W = 10,
    parameter int TRIG_W  = 12,
    parameter int X_OFS   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    brief_stream_desc_if.slave bus
);

    localparam int G     = NBITS / PAR;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int HALF  = WIN / 2;
    localparam int IDX_W = $clog2(WIN);
    localparam int PW    = 8 + TRIG_W;

    state_t                   state_r;
    state_t                   state_s;
    logic [GW-1:0]            g_r;
    logic                     drain_r;
    logic                     start_s;
    logic                     ready_r;
    logic                     valid_r;
    logic signed [TRIG_W-1:0] sin_r;
    logic signed [TRIG_W-1:0] cos_r;
    logic [COORD_W-1:0]       coor_x_r;
    logic [COORD_W-1:0]       coor_y_r;
    logic [7:0]               score_r;
    logic [9:0]               depth_r;
    logic [NBITS-1:0]         desc_r;

    point_t                   rom_a_s [PAR];
    point_t                   rom_b_s [PAR];
    point_t                   pt_s    [PAR][2];

    logic signed [PW-1:0]     s1_xc_r [PAR][2];
    logic signed [PW-1:0]     s1_xs_r [PAR][2];
    logic signed [PW-1:0]     s1_yc_r [PAR][2];
    logic signed [PW-1:0]     s1_ys_r [PAR][2];
    logic                     s1_v_r;
    logic [GW-1:0]            s1_g_r;
    logic signed [8:0]        s2_x_r  [PAR][2];
    logic signed [8:0]        s2_y_r  [PAR][2];
    logic                     s2_v_r;
    logic [GW-1:0]            s2_g_r;
    logic [7:0]               pix_s   [PAR][2];
    logic [PAR-1:0]           bits_s;

    brief_pattern_rom #(
        .WIN   (WIN),
        .NBITS (NBITS),
        .PAR   (PAR),
        .GW    (GW)
    ) u_rom (
        .g  (g_r),
        .pa (rom_a_s),
        .pb (rom_b_s)
    );

    assign start_s = (state_r == ST_IDLE) && bus.i_valid &&
                     (bus.i_coor_x != {COORD_W{1'b0}}) && (bus.i_coor_y != {COORD_W{1'b0}});

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (start_s)             state_s = ST_RUN;   else state_s = ST_IDLE;
            ST_RUN:   if (g_r == GW'(G - 1))   state_s = ST_DRAIN; else state_s = ST_RUN;
            ST_DRAIN: if (drain_r)             state_s = ST_OUT;   else state_s = ST_DRAIN;
            ST_OUT:   if (bus.i_ready)         state_s = ST_IDLE;  else state_s = ST_OUT;
            default:                           state_s = ST_IDLE;
        endcase
    end

    // control state, keypoint latches and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            g_r      <= {GW{1'b0}};
            drain_r  <= 1'b0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            sin_r    <= {TRIG_W{1'b0}};
            cos_r    <= {TRIG_W{1'b0}};
            coor_x_r <= {COORD_W{1'b0}};
            coor_y_r <= {COORD_W{1'b0}};
            score_r  <= 8'd0;
            depth_r  <= 10'd0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_IDLE);
            valid_r <= (state_s == ST_OUT);
            if ((state_r == ST_IDLE) && bus.i_valid) begin
                coor_x_r <= bus.i_coor_x - COORD_W'(X_OFS);
                coor_y_r <= bus.i_coor_y;
                score_r  <= bus.i_score;
                depth_r  <= bus.i_depth;
                sin_r    <= bus.i_unsteered ? {TRIG_W{1'b0}} : bus.i_sin;
                cos_r    <= bus.i_unsteered ? TRIG_W'(1 << Q_FRAC) : bus.i_cos;
            end
            if ((state_r == ST_RUN) && (g_r != GW'(G - 1))) begin
                g_r <= g_r + GW'(1);
            end else begin
                g_r <= {GW{1'b0}};
            end
            drain_r <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
        end
    end

    // arrange ROM outputs as [pair][A/B]
    always_comb begin
        for (int k = 0; k < PAR; k++) begin
            pt_s[k][0] = rom_a_s[k];
            pt_s[k][1] = rom_b_s[k];
        end
    end

    // S1 products and S2 rotation/rounding, with the group tag travelling alongside
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_v_r <= 1'b0;
            s1_g_r <= {GW{1'b0}};
            s2_v_r <= 1'b0;
            s2_g_r <= {GW{1'b0}};
            for (int k = 0; k < PAR; k++) begin
                for (int p = 0; p < 2; p++) begin
                    s1_xc_r[k][p] <= {PW{1'b0}};
                    s1_xs_r[k][p] <= {PW{1'b0}};
                    s1_yc_r[k][p] <= {PW{1'b0}};
                    s1_ys_r[k][p] <= {PW{1'b0}};
                    s2_x_r[k][p]  <= 9'sd0;
                    s2_y_r[k][p]  <= 9'sd0;
                end
            end
        end else begin
            s1_v_r <= (state_r == ST_RUN);
            s1_g_r <= g_r;
            s2_v_r <= s1_v_r;
            s2_g_r <= s1_g_r;
            for (int k = 0; k < PAR; k++) begin
                for (int p = 0; p < 2; p++) begin
                    s1_xc_r[k][p] <= PW'($signed(pt_s[k][p].x)) * PW'(cos_r);
                    s1_xs_r[k][p] <= PW'($signed(pt_s[k][p].x)) * PW'(sin_r);
                    s1_yc_r[k][p] <= PW'($signed(pt_s[k][p].y)) * PW'(cos_r);
                    s1_ys_r[k][p] <= PW'($signed(pt_s[k][p].y)) * PW'(sin_r);
                    s2_x_r[k][p]  <= round_q(21'(s1_xc_r[k][p]) - 21'(s1_ys_r[k][p]));
                    s2_y_r[k][p]  <= round_q(21'(s1_xs_r[k][p]) + 21'(s1_yc_r[k][p]));
                end
            end
        end
    end

    // S3 pixel fetch at the clamped rotated positions
    always_comb begin
        for (int k = 0; k < PAR; k++) begin
            for (int p = 0; p < 2; p++) begin
                pix_s[k][p] = bus.i_window[IDX_W'(clamp_idx(s2_y_r[k][p], HALF, WIN - 1))]
                                          [IDX_W'(clamp_idx(s2_x_r[k][p], HALF, WIN - 1))];
            end
        end
    end

    // S3 strict unsigned comparison per pair
    always_comb begin
        for (int k = 0; k < PAR; k++) begin
            bits_s[k] = (pix_s[k][0] > pix_s[k][1]);
        end
    end

    // descriptor register: cleared on start, each group ORed into its slot once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            desc_r <= {NBITS{1'b0}};
        end else if (start_s) begin
            desc_r <= {NBITS{1'b0}};
        end else if (s2_v_r) begin
            desc_r <= desc_r | (NBITS'(bits_s) << (int'(s2_g_r) * PAR));
        end else begin
            desc_r <= desc_r;
        end
    end

    assign bus.o_ready      = ready_r;
    assign bus.o_valid      = valid_r;
    assign bus.o_coor_x     = coor_x_r;
    assign bus.o_coor_y     = coor_y_r;
    assign bus.o_score      = score_r;
    assign bus.o_depth      = depth_r;
    assign bus.o_descriptor = desc_r;

endmodule

// File: tb/tb_brief_stream_desc.sv
// Self-checking bench for brief_stream_desc: directed vector table, hand-written
// backpressure/reset/drop sequences, and random keypoints against a rotation model.
module tb_brief_stream_desc;

    localparam int WIN = 31, NBITS = 256, PAR = 16, COORD_W = 10, TRIG_W = 12, X_OFS = 2;
    localparam int G = NBITS / PAR;
    localparam int HALF = WIN / 2;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] win_m [WIN][WIN];

    brief_stream_desc_if #(.WIN(WIN), .NBITS(NBITS), .COORD_W(COORD_W), .TRIG_W(TRIG_W)) bus ();

    brief_stream_desc #(
        .WIN(WIN), .NBITS(NBITS), .PAR(PAR), .COORD_W(COORD_W), .TRIG_W(TRIG_W), .X_OFS(X_OFS)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int               wmode;
        int               x, y, score, depth, s, c;
        bit               unst;
        bit               use_model;
        logic [NBITS-1:0] desc;
        int               ox, oy;
    } vec_t;

    task automatic check(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // pattern table definition: pair i, component 0..3 = xa, ya, xb, yb
    function automatic int pat(input int i, input int comp);
        case (comp)
            0:       return HALF - ((i * 11) % WIN);
            1:       return HALF - ((i * 17) % WIN);
            2:       return ((i * 23 + 13) % WIN) - HALF;
            default: return ((i * 29 + 7) % WIN) - HALF;
        endcase
    endfunction

    function automatic int place(input int v);
        int r;
        r = ((v + 512) >>> 10) + HALF;
        if (r < 0) r = 0;
        if (r > WIN - 1) r = WIN - 1;
        return r;
    endfunction

    function automatic logic [7:0] pix_at(input int px, input int py, input int s, input int c);
        return win_m[place(px * s + py * c)][place(px * c - py * s)];
    endfunction

    function automatic logic [NBITS-1:0] model(input int s, input int c, input bit unst);
        logic [NBITS-1:0] d;
        int ss, cc;
        ss = unst ? 0 : s;
        cc = unst ? 1024 : c;
        d = '0;
        for (int i = 0; i < NBITS; i++)
            d[i] = pix_at(pat(i, 0), pat(i, 1), ss, cc) > pix_at(pat(i, 2), pat(i, 3), ss, cc);
        return d;
    endfunction

    function automatic logic [NBITS-1:0] ident_bits();
        logic [NBITS-1:0] d;
        for (int i = 0; i < NBITS; i++) d[i] = pat(i, 0) > pat(i, 2);
        return d;
    endfunction

    function automatic logic [NBITS-1:0] rot90_bits();
        logic [NBITS-1:0] d;
        for (int i = 0; i < NBITS; i++) d[i] = (-pat(i, 1)) > (-pat(i, 3));
        return d;
    endfunction

    task automatic set_window(input int mode);
        int v;
        for (int yy = 0; yy < WIN; yy++) begin
            for (int xx = 0; xx < WIN; xx++) begin
                case (mode)
                    0:       v = 0;
                    1:       v = xx;
                    2:       v = yy;
                    default: v = int'($urandom_range(0, 255));
                endcase
                win_m[yy][xx] = 8'(v);
                bus.i_window[yy][xx] = 8'(v);
            end
        end
    endtask

    // called and returns at posedge+1; acc is the accept cycle number
    task automatic send(input int x, input int y, input int score, input int depth,
                        input int s, input int c, input bit unst, output int acc);
        int w;
        w = 0;
        while (!bus.o_ready && w < 50) begin
            @(posedge i_clk); #1;
            w++;
        end
        if (!bus.o_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: o_ready still %0b after %0d cycles", bus.o_ready, w);
        end
        acc = cyc;
        bus.i_coor_x = COORD_W'(x);
        bus.i_coor_y = COORD_W'(y);
        bus.i_score = 8'(score);
        bus.i_depth = 10'(depth);
        bus.i_sin = TRIG_W'(s);
        bus.i_cos = TRIG_W'(c);
        bus.i_unsteered = unst;
        bus.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int vc, output bit got);
        got = 1'b0;
        vc = 0;
        for (int n = 0; n < lim; n++) begin
            if (bus.o_valid) begin
                got = 1'b1;
                vc = cyc;
                break;
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic handshake(output int hc);
        hc = cyc;
        bus.i_ready = 1'b1;
        @(posedge i_clk); #1;
        bus.i_ready = 1'b0;
    endtask

    vec_t             vt [5];
    logic [NBITS-1:0] exp_d;
    int               acc, vc, hc, dly, rx, ry, rs, rc, rsc, rdp;
    bit               got, ru;

    initial begin
        i_rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_coor_x = '0;
        bus.i_coor_y = '0;
        bus.i_score = '0;
        bus.i_depth = '0;
        bus.i_sin = '0;
        bus.i_cos = '0;
        bus.i_unsteered = 1'b0;
        set_window(0);

        vt[0] = '{0, 100, 50, 165, 700, 0, 1024, 1'b0, 1'b0, '0, 98, 50};
        vt[1] = '{1, 200, 300, 7, 1, 0, 1024, 1'b0, 1'b0, ident_bits(), 198, 300};
        vt[2] = '{1, 3, 1, 255, 1023, 1024, 0, 1'b0, 1'b0, rot90_bits(), 1, 1};
        vt[3] = '{1, 1, 1023, 0, 0, 1024, 0, 1'b1, 1'b0, ident_bits(), 1023, 1023};
        vt[4] = '{2, 500, 500, 66, 512, 724, 724, 1'b0, 1'b1, '0, 498, 500};

        #12;
        check("rst_ready", bus.o_ready, 1);
        check("rst_valid", bus.o_valid, 0);
        check("rst_desc", bus.o_descriptor, 0);
        check("rst_x", bus.o_coor_x, 0);
        check("rst_y", bus.o_coor_y, 0);
        check("rst_score", bus.o_score, 0);
        check("rst_depth", bus.o_depth, 0);
        #2 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int n = 0; n < 5; n++) begin
            set_window(vt[n].wmode);
            exp_d = vt[n].use_model ? model(vt[n].s, vt[n].c, vt[n].unst) : vt[n].desc;
            send(vt[n].x, vt[n].y, vt[n].score, vt[n].depth, vt[n].s, vt[n].c, vt[n].unst, acc);
            check($sformatf("v%0d_busy", n), bus.o_ready, 0);
            wait_valid(60, vc, got);
            check($sformatf("v%0d_seen", n), got, 1);
            check($sformatf("v%0d_lat", n), vc - acc, G + 3);
            check($sformatf("v%0d_desc", n), bus.o_descriptor, exp_d);
            check($sformatf("v%0d_x", n), bus.o_coor_x, vt[n].ox);
            check($sformatf("v%0d_y", n), bus.o_coor_y, vt[n].oy);
            check($sformatf("v%0d_score", n), bus.o_score, vt[n].score);
            check($sformatf("v%0d_depth", n), bus.o_depth, vt[n].depth);
            if (n == 4) check("v4_clamp_bit0", bus.o_descriptor[0], 1);
            handshake(hc);
            check($sformatf("v%0d_ready_after", n), bus.o_ready, 1);
            check($sformatf("v%0d_valid_after", n), bus.o_valid, 0);
        end

        // backpressure for 10 cycles, then immediate second keypoint
        set_window(1);
        send(40, 41, 9, 10, 0, 1024, 1'b0, acc);
        wait_valid(60, vc, got);
        check("bp_seen", got, 1);
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", bus.o_valid, 1);
            check("bp_ready", bus.o_ready, 0);
            check("bp_desc", bus.o_descriptor, ident_bits());
            check("bp_x", bus.o_coor_x, 38);
            @(posedge i_clk); #1;
        end
        handshake(hc);
        check("bp_ready_release", bus.o_ready, 1);
        send(60, 61, 11, 12, 1024, 0, 1'b0, acc);
        check("b2b_accept_cycle", acc, hc + 1);
        wait_valid(60, vc, got);
        check("b2b_seen", got, 1);
        check("b2b_period", vc - hc, G + 4);
        check("b2b_desc", bus.o_descriptor, rot90_bits());
        check("b2b_x", bus.o_coor_x, 58);
        handshake(hc);

        // asynchronous reset while group 7 is being issued
        send(10, 10, 3, 4, 0, 1024, 1'b0, acc);
        repeat (7) begin @(posedge i_clk); #1; end
        exp_d = ident_bits() & ((NBITS'(1) << (5 * PAR)) - NBITS'(1));
        check("partial_desc", bus.o_descriptor, exp_d);
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", bus.o_ready, 1);
        check("mid_rst_valid", bus.o_valid, 0);
        check("mid_rst_desc", bus.o_descriptor, 0);
        check("mid_rst_x", bus.o_coor_x, 0);
        check("mid_rst_score", bus.o_score, 0);
        #10 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // dropped keypoints: ready stays high, nothing emitted
        send(0, 5, 1, 1, 0, 1024, 1'b0, acc);
        check("drop_x_ready", bus.o_ready, 1);
        wait_valid(40, vc, got);
        check("drop_x_no_valid", got, 0);
        send(5, 0, 1, 1, 0, 1024, 1'b0, acc);
        check("drop_y_ready", bus.o_ready, 1);
        wait_valid(30, vc, got);
        check("drop_y_no_valid", got, 0);

        // randomized keypoints against the model
        for (int n = 0; n < 8; n++) begin
            set_window(3);
            rx = int'($urandom_range(1, 1023));
            ry = int'($urandom_range(1, 1023));
            rs = int'($urandom_range(0, 2048)) - 1024;
            rc = int'($urandom_range(0, 2048)) - 1024;
            rsc = int'($urandom_range(0, 255));
            rdp = int'($urandom_range(0, 1023));
            ru = ($urandom_range(0, 3) == 0);
            exp_d = model(rs, rc, ru);
            send(rx, ry, rsc, rdp, rs, rc, ru, acc);
            wait_valid(60, vc, got);
            check("rnd_seen", got, 1);
            check("rnd_lat", vc - acc, G + 3);
            dly = int'($urandom_range(0, 3));
            repeat (dly) begin @(posedge i_clk); #1; end
            check("rnd_hold", bus.o_valid, 1);
            check("rnd_desc", bus.o_descriptor, exp_d);
            check("rnd_x", bus.o_coor_x, (rx - X_OFS) & 1023);
            check("rnd_y", bus.o_coor_y, ry);
            check("rnd_score", bus.o_score, rsc);
            check("rnd_depth", bus.o_depth, rdp);
            handshake(hc);
            check("rnd_ready_after", bus.o_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
